traffic_timer: RTL and testbench
================================

Name: traffic_timer

Overview:
- Parametrised interval timer for the traffic-light controller; successor to the fixed 4-bit short/long timeout counter.
- Counts prescaled ticks after a start pulse and emits one-cycle short-timeout (ts) and long-timeout (tl) pulses at run-time programmable thresholds.
- Supports one-shot or auto-reload operation and can be aborted.
- The controller FSM drives st/stop and consumes ts/tl.

Parameters:
- W, 8, counter and threshold width in bits.
- PRESCALE, 1, clk cycles per tick; 1 means a tick every cycle; legal range 1..65535.
- DEF_SHORT, 4, short threshold latched at reset.
- DEF_LONG, 16, long threshold latched at reset; must be < 2^W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st  in  1  synchronous start/restart pulse.
- stop  in  1  synchronous abort.
- auto_rl  in  1  1 = auto-reload, 0 = one-shot; sampled on st.
- short_thr  in  W  short threshold; sampled on st; 0 disables ts.
- long_thr  in  W  long threshold; sampled on st; 0 means 2^W ticks.
- ts  out  1  one-cycle short-timeout pulse.
- tl  out  1  one-cycle long-timeout pulse.
- busy  out  1  high in RUN.
- count  out  W  current tick count.

Behaviour:
- Reset (rst_n low, async): state IDLE; count=0; prescaler=0; ts=tl=busy=0; latched thresholds = DEF_SHORT/DEF_LONG; latched mode = one-shot.
- States:
  - IDLE: count holds 0.
  - RUN: counting.
  - DONE: one-shot expired; count holds the final value.
- Start:
  - st=1 in any state: count←0, prescaler←0, latch short_thr/long_thr/auto_rl, state←RUN, busy=1 from the next cycle.
  - No ts/tl pulse is produced in the st cycle.
- Tick:
  - Prescaler counts 0..PRESCALE-1 while in RUN; tick = prescaler==PRESCALE-1. With PRESCALE=1, tick is high every RUN cycle.
  - On a tick, count←count+1 (mod 2^W).
- Outputs are registered. A pulse goes high for exactly one clk, in the cycle after the edge where the tick moves count to the threshold:
  - ts when the new count == latched short (short ≠ 0).
  - tl when the new count == latched long; with long=0, tl fires on the wrap to 0.
  - With PRESCALE>1, count holds for PRESCALE cycles but the pulse is still one cycle.
- On tl:
  - One-shot: state←DONE, busy←0, count holds the threshold value (0 for long=0).
  - Auto-reload: count←0 on the same edge (the count output shows 0 in the pulse cycle), prescaler restarts, stay RUN.
- Boundaries:
  - short == long: ts and tl pulse in the same cycle.
  - short > long: ts never fires.
  - st and stop in the same cycle: st wins.
  - stop=1 (no st): state←IDLE, count←0, busy←0, ts/tl←0 next cycle. Any pending pulse is suppressed.
  - st while RUN: restart immediately; any pulse that would fire on that edge is suppressed.
  - Threshold input changes while RUN have no effect until the next st.
  - Reset mid-run: immediate return to reset values.

Optional Feature:
- Macro: TRAFFIC_TIMER_REMAIN_EN.
- Defined: adds output port remain [W-1:0] = latched long − count (mod 2^W), registered with count. It reads 0 in DONE and IDLE, and reads 0 in the auto-reload tl cycle.
- Undefined: no remain port and no subtractor logic. All other behaviour is identical.

Decomposition:
- Package traffic_timer_pkg:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - prescaler width function clog2(PRESCALE);
  - default threshold constants.
- One sub-module: tick_prescaler. Inputs clk, rst_n, clr, en; output tick. A free-running divide-by-PRESCALE counter; clr has priority.

Test Plan:
1. W=8, PRESCALE=1, short=4, long=10, one-shot; st at edge E0 → ts high only in the cycle after E4, tl only in the cycle after E10; busy falls after E10; count stays 10.
2. Same thresholds, auto_rl=1 → tl after E10, E20, E30; ts after E4, E14, E24; count shows 0 in each tl cycle; busy stays 1.
3. PRESCALE=3, short=2, long=3 → count increments every 3 cycles; ts after E6 and tl after E9, each exactly one cycle wide.
4. st again at E7 of scenario 1 → count=0 after E7; ts after E11 and tl after E17. Separately, stop at E5 → IDLE, no tl ever.
5. short=5, long=5 → ts and tl in the same cycle after E5. short=0 → no ts. long=0, W=4 → tl after E16.
6. rst_n low mid-run at count=6 → count, ts, tl, busy drop to 0 asynchronously. After release, IDLE with no pulses until st.

Source files
------------

// File: rtl/traffic_timer_pkg.sv
// Shared types and constants for the traffic-light interval timer.
// Optional remain output is controlled by TRAFFIC_TIMER_REMAIN_EN (see traffic_timer.sv).
package traffic_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_SHORT_THR = 4;
    localparam int DEF_LONG_THR  = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // A divide-by-1 prescaler still needs a one-bit register.
    function automatic int presc_width(input int prescale);
        return (clog2(prescale) < 1) ? 1 : clog2(prescale);
    endfunction

endpackage

// File: rtl/traffic_timer_if.sv
// Controller <-> timer signal bundle; remain exists only with TRAFFIC_TIMER_REMAIN_EN.
interface traffic_timer_if #(parameter int W = 8);

    logic         st;
    logic         stop;
    logic         auto_rl;
    logic [W-1:0] short_thr;
    logic [W-1:0] long_thr;
    logic         ts;
    logic         tl;
    logic         busy;
    logic [W-1:0] count;
`ifdef TRAFFIC_TIMER_REMAIN_EN
    logic [W-1:0] remain;

    modport master (output st, stop, auto_rl, short_thr, long_thr,
                    input  ts, tl, busy, count, remain);
    modport slave  (input  st, stop, auto_rl, short_thr, long_thr,
                    output ts, tl, busy, count, remain);
`else
    modport master (output st, stop, auto_rl, short_thr, long_thr,
                    input  ts, tl, busy, count);
    modport slave  (input  st, stop, auto_rl, short_thr, long_thr,
                    output ts, tl, busy, count);
`endif

endinterface

// File: rtl/traffic_timer_tick.sv
// Divide-by-PRESCALE tick generator; clr restarts the division and overrides en.
module tick_prescaler
    import traffic_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             PW   = presc_width(PRESCALE);
    localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick = en && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_timer.sv
// Interval timer with programmable short/long pulses, one-shot or auto-reload.
// Define TRAFFIC_TIMER_REMAIN_EN to add the registered remain (long - count) output.
//
// state | meaning
// IDLE  | stopped, count held at 0
// RUN   | counting prescaled ticks
// DONE  | one-shot expired, count holds final value
module traffic_timer
    import traffic_timer_pkg::*;
#(
    parameter int W         = 8,
    parameter int PRESCALE  = 1,
    parameter int DEF_SHORT = DEF_SHORT_THR,
    parameter int DEF_LONG  = DEF_LONG_THR
) (
    input  logic           clk,
    input  logic           rst_n,
    traffic_timer_if.slave tif
);

    state_e       state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] short_q, short_d;
    logic [W-1:0] long_q, long_d;
    logic         auto_q, auto_d;
    logic         ts_q, ts_d;
    logic         tl_q, tl_d;
    logic         tick;
    logic         presc_clr;
    logic [W-1:0] count_inc;

    assign count_inc = count_q + W'(1);

    tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .en    (state_q == ST_RUN),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        short_d   = short_q;
        long_d    = long_q;
        auto_d    = auto_q;
        ts_d      = 1'b0;
        tl_d      = 1'b0;
        presc_clr = 1'b0;
        if (tif.st) begin
            state_d   = ST_RUN;
            count_d   = '0;
            short_d   = tif.short_thr;
            long_d    = tif.long_thr;
            auto_d    = tif.auto_rl;
            presc_clr = 1'b1;
        end else if (tif.stop) begin
            state_d   = ST_IDLE;
            count_d   = '0;
            presc_clr = 1'b1;
        end else if (state_q == ST_RUN && tick) begin
            count_d = count_inc;
            ts_d    = (short_q != '0) && (count_inc == short_q);
            // long == 0 matches naturally on the wrap to zero
            if (count_inc == long_q) begin
                tl_d = 1'b1;
                if (auto_q) begin
                    count_d = '0;
                end else begin
                    state_d = ST_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            short_q <= W'(DEF_SHORT);
            long_q  <= W'(DEF_LONG);
            auto_q  <= 1'b0;
            ts_q    <= 1'b0;
            tl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            short_q <= short_d;
            long_q  <= long_d;
            auto_q  <= auto_d;
            ts_q    <= ts_d;
            tl_q    <= tl_d;
        end
    end

    assign tif.ts    = ts_q;
    assign tif.tl    = tl_q;
    assign tif.busy  = (state_q == ST_RUN);
    assign tif.count = count_q;

`ifdef TRAFFIC_TIMER_REMAIN_EN
    logic [W-1:0] remain_q, remain_d;

    // Zero outside RUN and in the auto-reload pulse cycle.
    assign remain_d = (state_d == ST_RUN && !tl_d) ? (long_d - count_d) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_q <= '0;
        end else begin
            remain_q <= remain_d;
        end
    end

    assign tif.remain = remain_q;
`endif

endmodule

// File: tb/tb_traffic_timer.sv
// Bench for traffic_timer: three instances (W8/P1, W8/P3, W4/P1) checked every cycle
// against an elapsed-time model, plus literal spot checks.
module tb_traffic_timer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    traffic_timer_if #(.W(8)) if0 ();
    traffic_timer_if #(.W(8)) if1 ();
    traffic_timer_if #(.W(4)) if2 ();

    traffic_timer #(.W(8), .PRESCALE(1)) u0 (.clk(clk), .rst_n(rst_n), .tif(if0));
    traffic_timer #(.W(8), .PRESCALE(3)) u1 (.clk(clk), .rst_n(rst_n), .tif(if1));
    traffic_timer #(.W(4), .PRESCALE(1)) u2 (.clk(clk), .rst_n(rst_n), .tif(if2));

    bit       st_v   [3];
    bit       stop_v [3];
    bit       auto_v [3];
    bit [7:0] sthr   [3];
    bit [7:0] lthr   [3];

    assign if0.st = st_v[0];  assign if0.stop = stop_v[0];  assign if0.auto_rl = auto_v[0];
    assign if1.st = st_v[1];  assign if1.stop = stop_v[1];  assign if1.auto_rl = auto_v[1];
    assign if2.st = st_v[2];  assign if2.stop = stop_v[2];  assign if2.auto_rl = auto_v[2];
    assign if0.short_thr = sthr[0];       assign if0.long_thr = lthr[0];
    assign if1.short_thr = sthr[1];       assign if1.long_thr = lthr[1];
    assign if2.short_thr = sthr[2][3:0];  assign if2.long_thr = lthr[2][3:0];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", nm, $time, act, exp);
        end
    endtask

    // Model: remembers only whether a run is active, edges since start and latched settings.
    typedef struct {
        bit act;
        int n;
        int s;
        int l;
        bit a;
    } mdl_t;

    mdl_t m [3];
    int   pw [3] = '{1, 3, 1};
    int   ww [3] = '{8, 8, 4};

    function automatic void model_out(input mdl_t mm, input int p, input int w,
                                      output int e_ts, output int e_tl,
                                      output int e_busy, output int e_cnt);
        int k, pp;
        bit edge_now;
        e_ts = 0; e_tl = 0; e_busy = 0; e_cnt = 0;
        if (mm.act) begin
            k = mm.n / p;
            edge_now = (mm.n > 0) && (mm.n % p == 0);
            if (!mm.a) begin
                e_busy = (k < mm.l) ? 1 : 0;
                e_cnt  = ((k >= mm.l) ? mm.l : k) % (1 << w);
                e_ts   = (edge_now && mm.s != 0 && k == mm.s && k <= mm.l) ? 1 : 0;
                e_tl   = (edge_now && k == mm.l) ? 1 : 0;
            end else begin
                pp     = (k == 0) ? 0 : ((k - 1) % mm.l) + 1;
                e_busy = 1;
                e_cnt  = (pp == mm.l) ? 0 : pp;
                e_ts   = (edge_now && mm.s != 0 && pp == mm.s) ? 1 : 0;
                e_tl   = (edge_now && pp == mm.l) ? 1 : 0;
            end
        end
    endfunction

    int a_ts [3], a_tl [3], a_busy [3], a_cnt [3];

    always_comb begin
        a_ts[0] = int'(if0.ts);  a_tl[0] = int'(if0.tl);  a_busy[0] = int'(if0.busy);  a_cnt[0] = int'(if0.count);
        a_ts[1] = int'(if1.ts);  a_tl[1] = int'(if1.tl);  a_busy[1] = int'(if1.busy);  a_cnt[1] = int'(if1.count);
        a_ts[2] = int'(if2.ts);  a_tl[2] = int'(if2.tl);  a_busy[2] = int'(if2.busy);  a_cnt[2] = int'(if2.count);
    end

    initial begin
        int e_ts, e_tl, e_busy, e_cnt, mask;
        for (int i = 0; i < 3; i++) m[i] = '{act: 1'b0, n: 0, s: 0, l: 1, a: 1'b0};
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                mask = (1 << ww[i]) - 1;
                if (!rst_n) begin
                    m[i].act = 1'b0;
                end else if (st_v[i]) begin
                    m[i].act = 1'b1;
                    m[i].n   = 0;
                    m[i].s   = int'(sthr[i]) & mask;
                    m[i].l   = int'(lthr[i]) & mask;
                    if (m[i].l == 0) m[i].l = 1 << ww[i];
                    m[i].a   = auto_v[i];
                end else if (stop_v[i]) begin
                    m[i].act = 1'b0;
                end else if (m[i].act) begin
                    m[i].n++;
                end
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                model_out(m[i], pw[i], ww[i], e_ts, e_tl, e_busy, e_cnt);
                chk($sformatf("u%0d.ts", i), a_ts[i], e_ts);
                chk($sformatf("u%0d.tl", i), a_tl[i], e_tl);
                chk($sformatf("u%0d.busy", i), a_busy[i], e_busy);
                chk($sformatf("u%0d.count", i), a_cnt[i], e_cnt);
            end
        end
    end

    // Called at a negedge; st is sampled on the next posedge (E0), returns at the following negedge.
    task automatic pulse_st(input int i, input int s, input int l, input bit a);
        st_v[i]   = 1'b1;
        sthr[i]   = 8'(s);
        lthr[i]   = 8'(l);
        auto_v[i] = a;
        @(negedge clk);
        st_v[i] = 1'b0;
    endtask

    task automatic pulse_stop(input int i);
        stop_v[i] = 1'b1;
        @(negedge clk);
        stop_v[i] = 1'b0;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        wait_edges(3);
        rst_n = 1'b1;
        chk("rst.busy", int'(if0.busy), 0);
        chk("rst.count", int'(if0.count), 0);
        wait_edges(2);

        // one-shot 4/10
        pulse_st(0, 4, 10, 1'b0);
        chk("s1.busy_e0", int'(if0.busy), 1);
        chk("s1.count_e0", int'(if0.count), 0);
        chk("s1.ts_e0", int'(if0.ts), 0);
        sthr[0] = 8'd2;
        lthr[0] = 8'd3;
        wait_edges(4);
        chk("s1.ts_e4", int'(if0.ts), 1);
        chk("s1.count_e4", int'(if0.count), 4);
        wait_edges(1);
        chk("s1.ts_e5", int'(if0.ts), 0);
        wait_edges(5);
        chk("s1.tl_e10", int'(if0.tl), 1);
        chk("s1.busy_e10", int'(if0.busy), 0);
        chk("s1.count_e10", int'(if0.count), 10);
        wait_edges(3);
        chk("s1.count_hold", int'(if0.count), 10);

        // auto-reload 4/10
        pulse_st(0, 4, 10, 1'b1);
        wait_edges(30);
        chk("s2.tl_e30", int'(if0.tl), 1);
        chk("s2.count_e30", int'(if0.count), 0);
        chk("s2.busy_e30", int'(if0.busy), 1);
        wait_edges(3);
        pulse_stop(0);
        chk("s2.stop_busy", int'(if0.busy), 0);
        wait_edges(2);

        // prescale 3, short 2, long 3
        pulse_st(1, 2, 3, 1'b0);
        wait_edges(6);
        chk("s3.ts_e6", int'(if1.ts), 1);
        chk("s3.count_e6", int'(if1.count), 2);
        wait_edges(3);
        chk("s3.tl_e9", int'(if1.tl), 1);
        chk("s3.count_e9", int'(if1.count), 3);
        wait_edges(1);
        chk("s3.tl_e10", int'(if1.tl), 0);

        // restart at E7
        pulse_st(0, 4, 10, 1'b0);
        wait_edges(6);
        pulse_st(0, 4, 10, 1'b0);
        chk("s4.count_e7", int'(if0.count), 0);
        wait_edges(4);
        chk("s4.ts_e11", int'(if0.ts), 1);
        wait_edges(6);
        chk("s4.tl_e17", int'(if0.tl), 1);
        wait_edges(2);

        // stop at E5, then st+stop together
        pulse_st(0, 4, 10, 1'b0);
        wait_edges(4);
        pulse_stop(0);
        chk("s4.stop_count", int'(if0.count), 0);
        wait_edges(12);
        stop_v[0] = 1'b1;
        pulse_st(0, 3, 6, 1'b0);
        stop_v[0] = 1'b0;
        chk("s4.st_wins_busy", int'(if0.busy), 1);
        wait_edges(8);

        // equal thresholds, disabled short, short > long, long = 0 on W=4
        pulse_st(0, 5, 5, 1'b0);
        wait_edges(5);
        chk("s5.ts_eq", int'(if0.ts), 1);
        chk("s5.tl_eq", int'(if0.tl), 1);
        wait_edges(2);
        pulse_st(0, 0, 10, 1'b0);
        wait_edges(12);
        pulse_st(0, 12, 10, 1'b1);
        wait_edges(25);
        pulse_st(2, 3, 0, 1'b0);
        wait_edges(16);
        chk("s5.w4_tl_e16", int'(if2.tl), 1);
        chk("s5.w4_count_e16", int'(if2.count), 0);
        wait_edges(2);

        // async reset mid-run at count 6
        pulse_st(0, 4, 10, 1'b0);
        wait_edges(6);
        chk("s6.count_pre", int'(if0.count), 6);
        #2 rst_n = 1'b0;
        #1;
        chk("s6.rst_count", int'(if0.count), 0);
        chk("s6.rst_busy", int'(if0.busy), 0);
        chk("s6.rst_ts", int'(if0.ts), 0);
        chk("s6.rst_tl", int'(if0.tl), 0);
        wait_edges(2);
        rst_n = 1'b1;
        wait_edges(15);
        chk("s6.idle_busy", int'(if0.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
